irq_priority_controller: RTL



---
 rtl/irq_priority_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/irq_priority_controller.sv
// Priority interrupt controller: edge-latched pending flags, software mask, in-service
// tracking and a registered irq/vector handshake. Define IRQ_NESTING_EN to allow preemption.
module irq_priority_controller #(
  parameter int         NUM_IRQ       = 8,
  parameter int         I_ADDR_WIDTH  = 10,
  parameter int         VECTOR_BASE   = 1,
  parameter int         VECTOR_STRIDE = 1,
  parameter logic [5:0] IMSK_ADDR     = 6'h3B,
  parameter logic [5:0] IFLG_ADDR     = 6'h3A,
  parameter logic [5:0] ISRV_ADDR     = 6'h39
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IRQ-1:0]      irq_lines,
  input  logic                    int_enable,
  output logic                    irq,
  output logic [I_ADDR_WIDTH-1:0] vector,
  input  logic                    ack,
  input  logic                    reti,
  input  logic [5:0]              io_addr,
  input  logic [7:0]              io_wdata,
  input  logic                    io_we,
  input  logic                    io_re,
  output logic [7:0]              io_rdata
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                  state;
  logic [NUM_IRQ-1:0]      prev;
  logic [NUM_IRQ-1:0]      pending;
  logic [NUM_IRQ-1:0]      mask;
  logic [NUM_IRQ-1:0]      inservice;
  logic [NUM_IRQ-1:0]      win_sel;

  logic [NUM_IRQ-1:0]      rise;
  logic [NUM_IRQ-1:0]      allow;
  logic [NUM_IRQ-1:0]      eligible;
  logic [NUM_IRQ-1:0]      winner;
  logic [NUM_IRQ-1:0]      isr_low;
  logic [NUM_IRQ-1:0]      pending_next;
  logic [NUM_IRQ-1:0]      inservice_next;
  logic                    win_found;
  logic [3:0]              win_num;
  logic [I_ADDR_WIDTH-1:0] win_vector;
  logic                    imsk_we;
  logic                    iflg_we;
  logic                    ack_take;

  assign rise     = irq_lines & ~prev;
  assign imsk_we  = io_we && (io_addr == IMSK_ADDR);
  assign iflg_we  = io_we && (io_addr == IFLG_ADDR);
  assign ack_take = (state == REQ) && ack;

`ifdef IRQ_NESTING_EN
  // Only channels strictly above the highest-priority in-service channel may preempt.
  always_comb begin : nest_allow
    logic blocked;
    blocked = 1'b0;
    allow   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      blocked  = blocked | inservice[i];
      allow[i] = ~blocked;
    end
  end
`else
  assign allow = (|inservice) ? '0 : '1;
`endif

  assign eligible = pending & mask & allow;

  // Descending scans so the lowest index is the final assignment.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    win_num   = '0;
    isr_low   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
        win_num   = 4'(i);
        win_found = 1'b1;
      end
      if (inservice[i]) begin
        isr_low    = '0;
        isr_low[i] = 1'b1;
      end
    end
  end

  assign win_vector = I_ADDR_WIDTH'(VECTOR_BASE + int'(win_num) * VECTOR_STRIDE);

  // A fresh rising edge is applied last so it survives a same-cycle clear.
  always_comb begin
    pending_next = pending;
    if (iflg_we)
      pending_next = pending_next & ~io_wdata[NUM_IRQ-1:0];
    if (ack_take)
      pending_next = pending_next & ~win_sel;
    pending_next = pending_next | rise;

    inservice_next = inservice;
    if (reti)
      inservice_next = inservice_next & ~isr_low;
    if (ack_take)
      inservice_next = inservice_next | win_sel;
  end

  always_comb begin
    io_rdata = '0;
    if (io_re) begin
      if (io_addr == IMSK_ADDR)      io_rdata = 8'(mask);
      else if (io_addr == IFLG_ADDR) io_rdata = 8'(pending);
      else if (io_addr == ISRV_ADDR) io_rdata = 8'(inservice);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= '0;
      pending   <= '0;
      mask      <= '0;
      inservice <= '0;
      win_sel   <= '0;
      irq       <= 1'b0;
      vector    <= '0;
    end else begin
      prev      <= irq_lines;
      pending   <= pending_next;
      inservice <= inservice_next;
      if (imsk_we)
        mask <= io_wdata[NUM_IRQ-1:0];
      case (state)
        IDLE: begin
          if (int_enable && win_found) begin
            irq     <= 1'b1;
            win_sel <= winner;
            vector  <= win_vector;
            state   <= REQ;
          end
        end
        REQ: begin
          if (ack || !int_enable) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
